// File: rtl/fp_pkg.sv
// ==== fp_pkg : shared binary32 field widths, constants and FPU types ==== rev 1.0
`default_nettype none

package fp_pkg;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN = 32'hFFC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  // Denormals (e==0) classify as ZERO, which is what flushes them.
  function automatic fp_class_t fp_classify(input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
    if (e == '0)      return ZERO;
    else if (e != '1) return NORM;
    else if (m == '0) return INF;
    else              return NAN;
  endfunction
endpackage

`default_nettype wire

// File: rtl/fdiv_step.sv
// ==== fdiv_step : one combinational restoring-division step ==== rev 1.0
`default_nettype none

module fdiv_step #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_div,
  input  logic         i_bit,
  output logic [W-1:0] o_rem,
  output logic         o_q
);
  logic [W:0] w_sh;
  logic [W:0] w_diff;

  // i_rem < i_div on entry, so both candidate remainders fit in W bits.
  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh - {1'b0, i_div};
  assign o_q    = ~w_diff[W];
  assign o_rem  = o_q ? w_diff[W-1:0] : w_sh[W-1:0];
endmodule

`default_nettype wire

// File: rtl/fdiv_iter.sv
// ==== fdiv_iter : iterative binary32 divider (restoring, RNE, FTZ) ==== rev 1.0
`default_nettype none

module fdiv_iter
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int QBITS          = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int                ITERS    = QBITS / BITS_PER_CYCLE;
  localparam int                CNT_W    = 5;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic signed [9:0] BIAS_S   = 10'(EXP_BIAS);

  fdiv_state_t r_state, w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_sign;
  logic                r_special;
  logic [31:0]         r_spec_y;
  logic signed [9:0]   r_exp;
  logic [23:0]         r_div;
  logic [23:0]         r_rem;
  logic [QBITS-1:0]    r_q;
  logic [QBITS-1:0]    r_nb;
  logic [31:0]         r_y;

  logic                w_accept;
  fp_class_t           w_c1, w_c2;
  logic                w_s;
  logic [23:0]         w_ma1, w_ma2;
  logic signed [9:0]   w_exp;
  logic                w_spec;
  logic [31:0]         w_spec_y;

  assign w_accept = in_valid && (r_state == IDLE);
  assign in_ready = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign y = r_y;

  assign w_c1  = fp_classify(x1[30:23], x1[22:0]);
  assign w_c2  = fp_classify(x2[30:23], x2[22:0]);
  assign w_s   = x1[31] ^ x2[31];
  assign w_ma1 = (x1[30:23] == '0) ? 24'd0 : {1'b1, x1[22:0]};
  assign w_ma2 = (x2[30:23] == '0) ? 24'd0 : {1'b1, x2[22:0]};
  assign w_exp = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]}) + BIAS_S;

  always_comb begin
    w_spec   = 1'b1;
    w_spec_y = QNAN;
    if (w_c1 == NAN)
      w_spec_y = {x1[31], {EXP_W{1'b1}}, 1'b1, x1[21:0]};
    else if (w_c2 == NAN)
      w_spec_y = {x2[31], {EXP_W{1'b1}}, 1'b1, x2[21:0]};
    else if ((w_c1 == ZERO && w_c2 == ZERO) || (w_c1 == INF && w_c2 == INF))
      w_spec_y = QNAN;
    else if (w_c1 == INF || w_c2 == ZERO)
      w_spec_y = PINF | {w_s, 31'd0};
    else if (w_c1 == ZERO || w_c2 == INF)
      w_spec_y = {w_s, 31'd0};
    else
      w_spec = 1'b0;
  end

  // Step chain: each stage consumes the next dividend bit and retires one quotient bit.
  logic [23:0]               w_rem_ch [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_qb;

  assign w_rem_ch[0] = r_rem;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    fdiv_step #(.W(24)) u_step (
      .i_rem (w_rem_ch[gi]),
      .i_div (r_div),
      .i_bit (r_nb[QBITS-1-gi]),
      .o_rem (w_rem_ch[gi+1]),
      .o_q   (w_qb[BITS_PER_CYCLE-1-gi])
    );
  end

  // Normalise, round to nearest even, then range-check.
  logic              w_norm;
  logic              w_rem_nz;
  logic [23:0]       w_man;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [24:0]       w_man_r;
  logic signed [9:0] w_e_n;
  logic signed [9:0] w_e_r;
  logic [22:0]       w_frac;
  logic [31:0]       w_result;

  assign w_norm   = r_q[QBITS-1];
  assign w_rem_nz = |r_rem;
  assign w_man    = w_norm ? r_q[25:2] : r_q[24:1];
  assign w_guard  = w_norm ? r_q[1] : r_q[0];
  assign w_sticky = w_norm ? (r_q[0] | w_rem_nz) : w_rem_nz;
  assign w_e_n    = w_norm ? r_exp : r_exp - 10'sd1;
  assign w_inc    = w_guard & (w_sticky | w_man[0]);
  assign w_man_r  = {1'b0, w_man} + {24'd0, w_inc};
  assign w_e_r    = w_man_r[24] ? w_e_n + 10'sd1 : w_e_n;
  assign w_frac   = w_man_r[24] ? 23'd0 : w_man_r[22:0];

  always_comb begin
    w_result = {r_sign, w_e_r[7:0], w_frac};
    if (r_special)
      w_result = r_spec_y;
    else if (w_e_r >= 10'sd255)
      w_result = PINF | {r_sign, 31'd0};
    else if (w_e_r <= 10'sd0)
      w_result = {r_sign, 31'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = DIV;
      DIV:     if (r_cnt == '0) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_spec_y  <= '0;
      r_exp     <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_nb      <= '0;
      r_y       <= '0;
    end else begin
      if (w_accept) begin
        r_cnt     <= CNT_LAST;
        r_sign    <= w_s;
        r_special <= w_spec;
        r_spec_y  <= w_spec_y;
        r_exp     <= w_exp;
        r_div     <= w_ma2;
        // Dividend is ma1<<25; its top 23 bits yield zero quotient bits, so preload them.
        r_rem     <= {1'b0, w_ma1[23:1]};
        r_nb      <= {w_ma1[0], {(QBITS-1){1'b0}}};
        r_q       <= '0;
      end else if (r_state == DIV) begin
        r_cnt <= r_cnt - 1'b1;
        r_rem <= w_rem_ch[BITS_PER_CYCLE];
        r_q   <= {r_q[QBITS-1-BITS_PER_CYCLE:0], w_qb};
        r_nb  <= r_nb << BITS_PER_CYCLE;
      end
      if (r_state == ROUND) r_y <= w_result;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fdiv_iter.sv
// ==== tb_fdiv_iter : directed-vector bench for fdiv_iter (1 and 2 bits/cycle) ==== rev 1.0
`default_nettype none

module tb_fdiv_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        rdy1, ov1, rdy2, ov2;
  logic [31:0] y1, y2;

  int total = 0;
  int bad   = 0;

  localparam int LAT1 = 28;
  localparam int LAT2 = 15;

  always #5 clk = ~clk;

  fdiv_iter #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(rdy1),
    .y(y1), .out_valid(ov1), .out_ready(out_ready)
  );

  fdiv_iter #(.BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(rdy2),
    .y(y2), .out_valid(ov2), .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got=%h expected=%h", nm, idx, got, exp);
    end
  endtask

  // Latency = edges from the accepting edge (counted as 1) to the edge where out_valid rises.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r2,
                        output int l1, output int l2);
    int cnt;
    bit s1, s2;
    s1 = 0; s2 = 0; l1 = -1; l2 = -1; r1 = '0; r2 = '0;
    x1 = a; x2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!(s1 && s2) && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
      if (ov1 && !s1) begin s1 = 1; l1 = cnt; r1 = y1; end
      if (ov2 && !s2) begin s2 = 1; l2 = cnt; r2 = y2; end
    end
    if (!(s1 && s2)) begin
      total++; bad++;
      $display("FAIL timeout: out_valid1=%0b out_valid2=%0b expected both high", s1, s2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    int l1, l2, n;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
    vecs[2]  = '{32'hC0F00000, 32'h40200000, 32'hC0400000};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'hFFC00000};
    vecs[5]  = '{32'h00000001, 32'h3F800000, 32'h00000000};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00001};
    vecs[7]  = '{32'h7F000000, 32'h3F000000, 32'h7F800000};
    vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{32'h80800000, 32'h40000000, 32'h80000000};
    vecs[10] = '{32'h7F800000, 32'h7F800000, 32'hFFC00000};
    vecs[11] = '{32'h3F800000, 32'hFF800001, 32'hFFC00001};
    vecs[12] = '{32'hC0000000, 32'h7F800000, 32'h80000000};
    vecs[13] = '{32'h7F800000, 32'hC0000000, 32'hFF800000};
    vecs[14] = '{32'h3F800000, 32'h80000000, 32'hFF800000};
    vecs[15] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB};
    vecs[16] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};

    // Reset state, observed mid-cycle while reset is held.
    #12;
    check("reset_ready_valid", 0, {31'd0, rdy1}, 32'd1);
    check("reset_ready_valid", 1, {31'd0, ov1}, 32'd0);
    check("reset_y", 0, y1, 32'h0);
    check("reset_y", 1, y2, 32'h0);
    check("reset_hs2", 0, {30'd0, rdy2, ov2}, 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, r1, r2, l1, l2);
      check("y_bpc1", i, r1, vecs[i].y);
      check("y_bpc2", i, r2, vecs[i].y);
      check("lat_bpc1", i, 32'(l1), 32'(LAT1));
      check("lat_bpc2", i, 32'(l2), 32'(LAT2));
    end

    // Backpressure: results must hold in DONE while out_ready stays low.
    x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!ov1 && n < 64) begin @(posedge clk); #1; n++; end
    check("bp_reached_done", 0, {31'd0, ov1}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_y1", c, y1, 32'h40400000);
      check("bp_y2", c, y2, 32'h40400000);
      check("bp_hs", c, {28'd0, ov1, rdy1, ov2, rdy2}, 32'b1010);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 0, {28'd0, rdy1, rdy2, ov1, ov2}, 32'b1100);

    // Asynchronous reset in the middle of DIV.
    x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 9; c++) @(posedge clk);
    #1;
    check("busy_before_rst", 0, {30'd0, rdy1, rdy2}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, {28'd0, rdy1, ov1, rdy2, ov2}, 32'b1010);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'h40C00000, 32'h40000000, r1, r2, l1, l2);
    check("post_rst_y1", 0, r1, 32'h40400000);
    check("post_rst_y2", 0, r2, 32'h40400000);
    check("post_rst_lat1", 0, 32'(l1), 32'(LAT1));
    check("post_rst_lat2", 0, 32'(l2), 32'(LAT2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
